// File: rtl/mailbox_pkg.sv
// Shared definitions for the test mailbox: FSM states, register offsets,
// CTRL bit positions and the code reported when a run ends with no results.
package mailbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE_PASS,
    ST_DONE_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_RESULT   = 3'd1;
  localparam logic [2:0] OFS_STATUS   = 3'd2;
  localparam logic [2:0] OFS_PASSCNT  = 3'd3;
  localparam logic [2:0] OFS_FAILCNT  = 3'd4;
  localparam logic [2:0] OFS_FAILCODE = 3'd5;
  localparam logic [2:0] OFS_WDOG     = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_END   = 1;
  localparam int CTRL_KICK  = 2;

  localparam logic [7:0] NO_RESULTS_CODE = 8'hFE;

endpackage

// File: rtl/mailbox_if.sv
// Core data-bus view seen by the mailbox: one access per strobed cycle,
// registered read data returned with a select flag.
interface mailbox_if;

  logic        stb;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rsel;

  modport master (
    output stb,
    output addr,
    output rw,
    output wdata,
    input  rdata,
    input  rsel
  );

  modport slave (
    input  stb,
    input  addr,
    input  rw,
    input  wdata,
    output rdata,
    output rsel
  );

endinterface

// File: rtl/sat_count8.sv
// 8-bit counter that sticks at 255; a synchronous clear beats an increment.
module sat_count8 (
  input  logic       ph2,
  input  logic       resetb,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/test_mailbox.sv
// Memory-mapped test-result responder: decodes the 8-byte window, counts
// results, latches the first failure, runs a watchdog and reports a verdict.
module test_mailbox
  import mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'hFFE0,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic       ph2,
  input  logic       resetb,
  mailbox_if.slave   bus,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] fail_code,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count
);

  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);

  state_t         state;
  state_t         next_state;
  logic [WDW-1:0] wdog;
  logic [7:0]     rdata_q;
  logic           rsel_q;
  logic [7:0]     rd_val;

  logic       hit;
  logic       wr_hit;
  logic       rd_hit;
  logic [2:0] ofs;
  logic       ctrl_wr;
  logic       res_wr;
  logic       start;
  logic       end_req;
  logic       kick;
  logic       running;
  logic       run_res;
  logic       run_end;
  logic       run_kick;
  logic       wdog_term;
  logic       res_zero;

  assign hit     = bus.stb && (bus.addr[15:3] == BASE_ADDR[15:3]);
  assign ofs     = bus.addr[2:0];
  assign wr_hit  = hit && !bus.rw;
  assign rd_hit  = hit && bus.rw;
  assign ctrl_wr = wr_hit && (ofs == OFS_CTRL);
  assign res_wr  = wr_hit && (ofs == OFS_RESULT);
  assign res_zero = (bus.wdata == 8'h00);

  // CTRL bits resolve START > END > KICK when more than one is set.
  assign start   = ctrl_wr && bus.wdata[CTRL_START];
  assign end_req = ctrl_wr && !bus.wdata[CTRL_START] && bus.wdata[CTRL_END];
  assign kick    = ctrl_wr && !bus.wdata[CTRL_START] && !bus.wdata[CTRL_END]
                   && bus.wdata[CTRL_KICK];

  assign running   = (state == ST_RUN);
  assign run_res   = running && res_wr;
  assign run_end   = running && end_req;
  assign run_kick  = running && kick;
  assign wdog_term = (TIMEOUT_CYCLES > 0) && (wdog == WDOG_LAST);

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A RESULT write, KICK or END on the terminal watchdog cycle overrides the timeout.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ST_RUN;
    end else if (running) begin
      if (end_req) begin
        if ((fail_count == 8'd0) && (pass_count != 8'd0)) begin
          next_state = ST_DONE_PASS;
        end else begin
          next_state = ST_DONE_FAIL;
        end
      end else if (run_res || run_kick) begin
        next_state = ST_RUN;
      end else if (wdog_term) begin
        next_state = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      wdog <= '0;
    end else if (running && (next_state == ST_RUN) && !start && !run_res && !run_kick) begin
      wdog <= wdog + WDW'(1);
    end else begin
      wdog <= '0;
    end
  end

  sat_count8 u_pass_count (
    .ph2    (ph2),
    .resetb (resetb),
    .clear  (start),
    .inc    (run_res && res_zero),
    .count  (pass_count)
  );

  sat_count8 u_fail_count (
    .ph2    (ph2),
    .resetb (resetb),
    .clear  (start),
    .inc    (run_res && !res_zero),
    .count  (fail_count)
  );

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      fail_code <= 8'h00;
    end else if (start) begin
      fail_code <= 8'h00;
    end else if (run_end && (pass_count == 8'd0) && (fail_count == 8'd0)) begin
      fail_code <= NO_RESULTS_CODE;
    end else if (run_res && !res_zero && (fail_count == 8'd0)) begin
      fail_code <= bus.wdata;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    case (ofs)
      OFS_STATUS:   rd_val = {4'b0000, timeout, pass, done, running};
      OFS_PASSCNT:  rd_val = pass_count;
      OFS_FAILCNT:  rd_val = fail_count;
      OFS_FAILCODE: rd_val = fail_code;
      OFS_WDOG:     rd_val = 8'(wdog);
      default:      rd_val = 8'h00;
    endcase
  end

  // Read data reflects register values before the edge that samples the access.
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      rdata_q <= 8'h00;
      rsel_q  <= 1'b0;
    end else begin
      rsel_q <= rd_hit;
      if (rd_hit) begin
        rdata_q <= rd_val;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rsel  = rsel_q;

  assign done    = (state == ST_DONE_PASS) || (state == ST_DONE_FAIL) || (state == ST_TIMEOUT);
  assign pass    = (state == ST_DONE_PASS);
  assign timeout = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_test_mailbox.sv
// Directed self-checking bench for test_mailbox, built with a 16-cycle
// watchdog so timeout behaviour is reachable in a short run.
module tb_test_mailbox;
  import mailbox_pkg::*;

  localparam logic [15:0] BASE = 16'hFFE0;

  logic       ph2;
  logic       resetb;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [7:0] fail_code;
  logic [7:0] pass_count;
  logic [7:0] fail_count;

  int checks;
  int errors;

  mailbox_if bus ();

  test_mailbox #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ph2        (ph2),
    .resetb     (resetb),
    .bus        (bus),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .pass_count (pass_count),
    .fail_count (fail_count)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  // Accesses are driven on the falling edge and sampled by the following rising edge.
  task automatic bus_write(input logic [2:0] o, input logic [7:0] d);
    @(negedge ph2);
    bus.stb   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = BASE + 16'(o);
    bus.wdata = d;
    @(negedge ph2);
    bus.stb   = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] o, output logic [7:0] d, output logic s);
    @(negedge ph2);
    bus.stb  = 1'b1;
    bus.rw   = 1'b1;
    bus.addr = BASE + 16'(o);
    @(negedge ph2);
    bus.stb  = 1'b0;
    d = bus.rdata;
    s = bus.rsel;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       s;
    resetb = 1'b0;
    #3;
    checks++;
    if ({done, pass, timeout, bus.rsel} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {done, pass, timeout, bus.rsel});
    end
    checks++;
    if ({pass_count, fail_count, fail_code, bus.rdata} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h expected 00000000", {pass_count, fail_count, fail_code, bus.rdata});
    end
    @(negedge ph2);
    resetb = 1'b1;
    bus_read(OFS_STATUS, d, s);
    checks++;
    if ({s, d} !== 9'h100) begin
      errors++;
      $display("[TB] FAIL idle_status: got rsel=%b data=%h expected rsel=1 data=00", s, d);
    end
    @(negedge ph2);
    checks++;
    if (bus.rsel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsel_pulse: got %b expected 0", bus.rsel);
    end
    bus_read(OFS_FAILCODE, d, s);
    checks++;
    if ({s, d} !== 9'h100) begin
      errors++;
      $display("[TB] FAIL idle_failcode: got rsel=%b data=%h expected rsel=1 data=00", s, d);
    end
    bus_write(OFS_STATUS, 8'h5A);
    checks++;
    if ({bus.rsel, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rsel_after_write: got %b expected 00", {bus.rsel, done});
    end
  endtask

  task automatic test_pass_run();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    bus_read(OFS_STATUS, d, s);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("[TB] FAIL run_status: got %h expected 01", d);
    end
    repeat (3) bus_write(OFS_RESULT, 8'h00);
    bus_write(OFS_CTRL, 8'h02);
    checks++;
    if ({done, pass, timeout, pass_count, fail_count} !== {3'b110, 8'd3, 8'd0}) begin
      errors++;
      $display("[TB] FAIL pass_verdict: got d=%b p=%b t=%b pc=%0d fc=%0d expected d=1 p=1 t=0 pc=3 fc=0",
               done, pass, timeout, pass_count, fail_count);
    end
    bus_read(OFS_STATUS, d, s);
    checks++;
    if (d[7:1] !== 7'h03) begin
      errors++;
      $display("[TB] FAIL pass_status: got %h expected 06 in bits 7:1 (timeout=0 pass=1 done=1)", d);
    end
    bus_read(OFS_PASSCNT, d, s);
    checks++;
    if (d !== 8'd3) begin
      errors++;
      $display("[TB] FAIL pass_count_read: got %h expected 03", d);
    end
  endtask

  task automatic test_fail_run();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    bus_write(OFS_RESULT, 8'h00);
    bus_write(OFS_RESULT, 8'h22);
    bus_write(OFS_RESULT, 8'h35);
    bus_write(OFS_CTRL, 8'h02);
    checks++;
    if ({done, pass, fail_code, fail_count, pass_count} !== {2'b10, 8'h22, 8'd2, 8'd1}) begin
      errors++;
      $display("[TB] FAIL fail_verdict: got d=%b p=%b fcode=%h fc=%0d pc=%0d expected d=1 p=0 fcode=22 fc=2 pc=1",
               done, pass, fail_code, fail_count, pass_count);
    end
    bus_read(OFS_FAILCODE, d, s);
    checks++;
    if (d !== 8'h22) begin
      errors++;
      $display("[TB] FAIL failcode_read: got %h expected 22", d);
    end
    bus_read(OFS_FAILCNT, d, s);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("[TB] FAIL failcnt_read: got %h expected 02", d);
    end
  endtask

  task automatic test_no_results();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    bus_write(OFS_CTRL, 8'h02);
    checks++;
    if ({done, pass, fail_code} !== {2'b10, 8'hFE}) begin
      errors++;
      $display("[TB] FAIL no_results: got d=%b p=%b fcode=%h expected d=1 p=0 fcode=fe", done, pass, fail_code);
    end
    bus_write(OFS_RESULT, 8'h55);
    bus_write(OFS_RESULT, 8'h00);
    checks++;
    if ({pass_count, fail_count, fail_code, done} !== {8'd0, 8'd0, 8'hFE, 1'b1}) begin
      errors++;
      $display("[TB] FAIL done_ignores_result: got pc=%0d fc=%0d fcode=%h d=%b expected pc=0 fc=0 fcode=fe d=1",
               pass_count, fail_count, fail_code, done);
    end
    bus_write(OFS_CTRL, 8'h07);
    bus_read(OFS_STATUS, d, s);
    checks++;
    if ({d, fail_code} !== {8'h01, 8'h00}) begin
      errors++;
      $display("[TB] FAIL ctrl07_start: got status=%h fcode=%h expected status=01 fcode=00", d, fail_code);
    end
    bus_write(OFS_CTRL, 8'h06);
    checks++;
    if ({done, timeout, fail_code} !== {2'b10, 8'hFE}) begin
      errors++;
      $display("[TB] FAIL end_over_kick: got d=%b t=%b fcode=%h expected d=1 t=0 fcode=fe", done, timeout, fail_code);
    end
    @(negedge ph2);
    resetb = 1'b0;
    @(negedge ph2);
    resetb = 1'b1;
    bus_write(OFS_RESULT, 8'h00);
    bus_write(OFS_CTRL, 8'h02);
    checks++;
    if ({pass_count, done} !== {8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL idle_ignores: got pc=%0d d=%b expected pc=0 d=0", pass_count, done);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    repeat (15) @(negedge ph2);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got %b expected 0 at cycle 15", timeout);
    end
    @(negedge ph2);
    checks++;
    if ({timeout, done, pass} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL timeout_at_16: got t/d/p=%b expected 110", {timeout, done, pass});
    end
    bus_read(OFS_STATUS, d, s);
    checks++;
    if (d !== 8'h0A) begin
      errors++;
      $display("[TB] FAIL timeout_status: got %h expected 0a", d);
    end
    bus_read(OFS_WDOG, d, s);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wdog_held: got %h expected 00", d);
    end
  endtask

  task automatic test_kick();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(negedge ph2);
      bus_write(OFS_CTRL, 8'h04);
    end
    repeat (8) @(negedge ph2);
    checks++;
    if ({timeout, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL kick_keeps_run: got t/d=%b expected 00", {timeout, done});
    end
    bus_read(OFS_STATUS, d, s);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("[TB] FAIL kick_status: got %h expected 01", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    repeat (14) @(negedge ph2);
    bus_write(OFS_RESULT, 8'h00);
    checks++;
    if ({timeout, done, pass_count} !== {2'b00, 8'd1}) begin
      errors++;
      $display("[TB] FAIL result_on_terminal: got t=%b d=%b pc=%0d expected t=0 d=0 pc=1", timeout, done, pass_count);
    end
    bus_read(OFS_WDOG, d, s);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("[TB] FAIL wdog_cleared: got %h expected 01", d);
    end
    bus_write(OFS_CTRL, 8'h01);
    repeat (14) @(negedge ph2);
    bus_write(OFS_CTRL, 8'h02);
    checks++;
    if ({timeout, done, pass, fail_code} !== {3'b010, 8'hFE}) begin
      errors++;
      $display("[TB] FAIL end_on_terminal: got t=%b d=%b p=%b fcode=%h expected t=0 d=1 p=0 fcode=fe",
               timeout, done, pass, fail_code);
    end
  endtask

  task automatic test_saturation_and_reset();
    logic [7:0] d;
    logic       s;
    bus_write(OFS_CTRL, 8'h01);
    for (int i = 0; i < 300; i++) begin
      bus_write(OFS_RESULT, 8'h00);
    end
    checks++;
    if ({pass_count, fail_count, done} !== {8'hFF, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL pass_saturate: got pc=%0d fc=%0d d=%b expected pc=255 fc=0 d=0", pass_count, fail_count, done);
    end
    bus_read(OFS_PASSCNT, d, s);
    checks++;
    if ({s, d} !== 9'h1FF) begin
      errors++;
      $display("[TB] FAIL sat_read: got rsel=%b data=%h expected rsel=1 data=ff", s, d);
    end
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if ({pass_count, fail_count, fail_code, bus.rdata, bus.rsel, done, pass, timeout} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got pc=%h fc=%h fcode=%h rdata=%h rsel=%b d=%b p=%b t=%b expected all 0",
               pass_count, fail_count, fail_code, bus.rdata, bus.rsel, done, pass, timeout);
    end
    @(negedge ph2);
    resetb = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resetb    = 1'b0;
    bus.stb   = 1'b0;
    bus.rw    = 1'b1;
    bus.addr  = 16'h0000;
    bus.wdata = 8'h00;
    test_reset();
    test_pass_run();
    test_fail_run();
    test_no_results();
    test_timeout();
    test_kick();
    test_back_to_back();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
